ov7670_capture_mb: RTL and testbench

- Parametrised OV7670 capture front-end; successor to the single-mode 1-bit double-buffer reader.
- Decodes the camera byte stream in the PCLK domain and emits a pixel-write stream to a multi-buffer frame store.
- Supports:
  - luma, thresholded-binary and RGB565 modes
  - optional 2x2 decimation
  - N-buffer rotation with a consumer read-lock
  - frame-error and drop reporting
- Sits between the camera pins and the frame-buffer RAMs; the consumer reads from the clock-divided system side.

---
 rtl/ov7670_capture_mb.sv | 175 +++++++++++++++++
 tb/tb_ov7670_capture_mb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture_mb.sv
// rtl/ov7670_capture_mb.sv - OV7670 byte-stream capture into a rotating multi-buffer frame store
module ov7670_capture_mb #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int NUM_BUF  = 2,
    parameter int BUF_W    = 2,
    parameter int ADDR_W   = 19
) (
    input  logic              PCLK,
    input  logic              Reset,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [7:0]        D,
    input  logic              Enable,
    input  logic [1:0]        Mode,
    input  logic [7:0]        Threshold,
    input  logic              Decimate,
    input  logic              LockValid,
    input  logic [BUF_W-1:0]  LockBuf,
    output logic              WrEn,
    output logic [BUF_W-1:0]  WrBuf,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [15:0]       WrData,
    output logic              FrameDone,
    output logic [BUF_W-1:0]  DoneBuf,
    output logic              FrameErr,
    output logic [7:0]        DropCount
);
    localparam int CW = $clog2(H_ACTIVE + 2);
    localparam int LW = $clog2(V_ACTIVE + 2);

    typedef enum logic [1:0] {WAIT_V, WAIT_H, LINE} state_t;

    state_t             state_q;
    logic               vsync_q, href_q, phase_q, err_q, dec_q;
    logic [1:0]         mode_q;
    logic [7:0]         thr_q, hi_q, drop_cnt_q;
    logic [CW-1:0]      col_q;
    logic [LW-1:0]      line_q;
    logic [ADDR_W-1:0]  addr_q, wr_addr_q;
    logic [BUF_W-1:0]   target_q, done_buf_q, wr_buf_q;
    logic               wr_en_q, frame_done_q, frame_err_q;
    logic [15:0]        wr_data_q;

    logic               vs_rise_d, vs_fall_d, hr_rise_d, write_ok_d, drop_d;
    logic [BUF_W-1:0]   cand0_d, cand_d;
    logic [15:0]        pix_d;

    function automatic logic [BUF_W-1:0] next_buf(input logic [BUF_W-1:0] b);
        return (b == BUF_W'(NUM_BUF - 1)) ? '0 : b + 1'b1;
    endfunction

    always_comb begin
        vs_rise_d  = VSYNC & ~vsync_q;
        vs_fall_d  = ~VSYNC & vsync_q;
        hr_rise_d  = HREF & ~href_q;
        // Skip past the consumer's buffer; drop if that lands back on the last good frame.
        cand0_d    = next_buf(done_buf_q);
        cand_d     = (LockValid && LockBuf == cand0_d) ? next_buf(cand0_d) : cand0_d;
        drop_d     = (cand_d == done_buf_q) || (LockValid && LockBuf == cand_d);
        write_ok_d = (col_q < CW'(H_ACTIVE)) && (line_q < LW'(V_ACTIVE)) &&
                     (!dec_q || (!col_q[0] && !line_q[0]));
        case (mode_q)
            2'd1:    pix_d = {15'd0, (D >= thr_q)};
            2'd2:    pix_d = {hi_q, D};
            default: pix_d = {8'd0, D};
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (Reset) begin
            state_q      <= WAIT_V;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            phase_q      <= 1'b0;
            err_q        <= 1'b0;
            dec_q        <= 1'b0;
            mode_q       <= 2'd0;
            thr_q        <= 8'd0;
            hi_q         <= 8'd0;
            drop_cnt_q   <= 8'd0;
            col_q        <= '0;
            line_q       <= '0;
            addr_q       <= '0;
            wr_addr_q    <= '0;
            target_q     <= '0;
            done_buf_q   <= BUF_W'(NUM_BUF - 1);
            wr_buf_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= 16'd0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            vsync_q      <= VSYNC;
            href_q       <= HREF;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                WAIT_V: begin
                    if (vs_fall_d) begin
                        mode_q <= (Mode == 2'd3) ? 2'd0 : Mode;
                        thr_q  <= Threshold;
                        dec_q  <= Decimate;
                        addr_q <= '0;
                        line_q <= '0;
                        col_q  <= '0;
                        err_q  <= 1'b0;
                        if (Enable) begin
                            if (drop_d) begin
                                if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
                            end else begin
                                target_q <= cand_d;
                                state_q  <= WAIT_H;
                            end
                        end
                    end
                end
                WAIT_H: begin
                    if (vs_rise_d) begin
                        if (line_q == LW'(V_ACTIVE) && !err_q) begin
                            frame_done_q <= 1'b1;
                            done_buf_q   <= target_q;
                        end else begin
                            frame_err_q  <= 1'b1;
                        end
                        state_q <= WAIT_V;
                    end else if (hr_rise_d) begin
                        hi_q    <= D;
                        phase_q <= 1'b1;
                        col_q   <= '0;
                        state_q <= LINE;
                    end
                end
                LINE: begin
                    if (vs_rise_d) begin
                        frame_err_q <= 1'b1;
                        state_q     <= WAIT_V;
                    end else if (HREF) begin
                        if (!phase_q) begin
                            hi_q    <= D;
                            phase_q <= 1'b1;
                        end else begin
                            phase_q <= 1'b0;
                            if (write_ok_d) begin
                                wr_en_q   <= 1'b1;
                                wr_buf_q  <= target_q;
                                wr_addr_q <= addr_q;
                                wr_data_q <= pix_d;
                                addr_q    <= addr_q + 1'b1;
                            end
                            if (col_q != CW'(H_ACTIVE + 1)) col_q <= col_q + 1'b1;
                        end
                    end else begin
                        if (phase_q || col_q != CW'(H_ACTIVE) || line_q >= LW'(V_ACTIVE))
                            err_q <= 1'b1;
                        if (line_q != LW'(V_ACTIVE + 1)) line_q <= line_q + 1'b1;
                        phase_q <= 1'b0;
                        state_q <= WAIT_H;
                    end
                end
                default: state_q <= WAIT_V;
            endcase
        end
    end

    assign WrEn      = wr_en_q;
    assign WrBuf     = wr_buf_q;
    assign WrAddr    = wr_addr_q;
    assign WrData    = wr_data_q;
    assign FrameDone = frame_done_q;
    assign DoneBuf   = done_buf_q;
    assign FrameErr  = frame_err_q;
    assign DropCount = drop_cnt_q;
endmodule

// File: tb/tb_ov7670_capture_mb.sv
// tb/tb_ov7670_capture_mb.sv - directed bench for ov7670_capture_mb on an 8x4 frame
module tb_ov7670_capture_mb;
    localparam int H = 8;
    localparam int V = 4;

    logic       PCLK = 1'b0;
    logic       Reset = 1'b1;
    logic       VSYNC = 1'b1;
    logic       HREF = 1'b0;
    logic [7:0] D = 8'd0;
    logic       Enable = 1'b1;
    logic [1:0] Mode = 2'd0;
    logic [7:0] Threshold = 8'h80;
    logic       Decimate = 1'b0;
    logic       LockValid = 1'b0;
    logic [1:0] LockBuf = 2'd0;

    logic        WrEn, FrameDone, FrameErr;
    logic [1:0]  WrBuf, DoneBuf;
    logic [4:0]  WrAddr;
    logic [15:0] WrData;
    logic [7:0]  DropCount;

    logic        WrEn3, FrameDone3, FrameErr3;
    logic [1:0]  WrBuf3, DoneBuf3;
    logic [4:0]  WrAddr3;
    logic [15:0] WrData3;
    logic [7:0]  DropCount3;

    ov7670_capture_mb #(.H_ACTIVE(H), .V_ACTIVE(V), .NUM_BUF(2), .BUF_W(2), .ADDR_W(5)) dut2 (
        .PCLK(PCLK), .Reset(Reset), .VSYNC(VSYNC), .HREF(HREF), .D(D), .Enable(Enable),
        .Mode(Mode), .Threshold(Threshold), .Decimate(Decimate), .LockValid(LockValid),
        .LockBuf(LockBuf), .WrEn(WrEn), .WrBuf(WrBuf), .WrAddr(WrAddr), .WrData(WrData),
        .FrameDone(FrameDone), .DoneBuf(DoneBuf), .FrameErr(FrameErr), .DropCount(DropCount));

    ov7670_capture_mb #(.H_ACTIVE(H), .V_ACTIVE(V), .NUM_BUF(3), .BUF_W(2), .ADDR_W(5)) dut3 (
        .PCLK(PCLK), .Reset(Reset), .VSYNC(VSYNC), .HREF(HREF), .D(D), .Enable(Enable),
        .Mode(Mode), .Threshold(Threshold), .Decimate(Decimate), .LockValid(LockValid),
        .LockBuf(LockBuf), .WrEn(WrEn3), .WrBuf(WrBuf3), .WrAddr(WrAddr3), .WrData(WrData3),
        .FrameDone(FrameDone3), .DoneBuf(DoneBuf3), .FrameErr(FrameErr3), .DropCount(DropCount3));

    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_err = 0;

    logic [4:0]  mon_addr [0:2047];
    logic [15:0] mon_data [0:2047];
    logic [1:0]  mon_buf  [0:2047];
    int          mon_n = 0;
    int          wr3_n = 0;
    logic [1:0]  wr3_buf = 2'd0;
    int          done_n = 0;
    int          ferr_n = 0;

    always @(negedge PCLK) begin
        if (WrEn === 1'b1 && mon_n < 2048) begin
            mon_addr[mon_n] = WrAddr;
            mon_data[mon_n] = WrData;
            mon_buf[mon_n]  = WrBuf;
            mon_n = mon_n + 1;
        end
        if (WrEn3 === 1'b1) begin
            wr3_n   = wr3_n + 1;
            wr3_buf = WrBuf3;
        end
        if (FrameDone === 1'b1) done_n = done_n + 1;
        if (FrameErr === 1'b1) ferr_n = ferr_n + 1;
    end

    function automatic logic [7:0] byte_of(input int pat, input int l, input int p, input int ph);
        int k;
        k = l * H + p;
        case (pat)
            0:       return (ph == 0) ? 8'h10 : 8'(k);
            1:       return (ph == 0) ? 8'h10 : (((k % 2) != 0) ? 8'h80 : 8'h7F);
            2:       return (ph == 0) ? 8'hF8 : 8'h1F;
            default: return (ph == 0) ? 8'hF8 : 8'(k);
        endcase
    endfunction

    task automatic drive_frame(input int nl, input int np, input int pat,
                               output logic fd, output logic fe, output logic after);
        @(negedge PCLK);
        VSYNC = 1'b1; HREF = 1'b0;
        repeat (3) @(negedge PCLK);
        VSYNC = 1'b0;
        repeat (3) @(negedge PCLK);
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < np; p++) begin
                for (int ph = 0; ph < 2; ph++) begin
                    HREF = 1'b1;
                    D = byte_of(pat, l, p, ph);
                    @(negedge PCLK);
                end
            end
            HREF = 1'b0; D = 8'd0;
            repeat (2) @(negedge PCLK);
        end
        VSYNC = 1'b1;
        @(negedge PCLK);
        fd = FrameDone; fe = FrameErr;
        @(negedge PCLK);
        after = FrameDone | FrameErr;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge PCLK);
        n_vec++; if (WrEn !== 1'b0) begin n_err++; $display("FAIL reset_wren got=%b exp=0", WrEn); end
        n_vec++; if (WrAddr !== 5'd0 || WrData !== 16'd0 || WrBuf !== 2'd0) begin n_err++; $display("FAIL reset_wr got addr=%0d data=%h buf=%0d exp 0/0/0", WrAddr, WrData, WrBuf); end
        n_vec++; if (FrameDone !== 1'b0 || FrameErr !== 1'b0) begin n_err++; $display("FAIL reset_pulses got done=%b err=%b exp 0/0", FrameDone, FrameErr); end
        n_vec++; if (DropCount !== 8'd0) begin n_err++; $display("FAIL reset_drop got=%0d exp=0", DropCount); end
        n_vec++; if (DoneBuf !== 2'd1) begin n_err++; $display("FAIL reset_donebuf2 got=%0d exp=1", DoneBuf); end
        n_vec++; if (DoneBuf3 !== 2'd2) begin n_err++; $display("FAIL reset_donebuf3 got=%0d exp=2", DoneBuf3); end
        Reset = 1'b0;
    endtask

    task automatic test_luma();
        int base; logic fd, fe, after;
        Mode = 2'd0; Decimate = 1'b0; base = mon_n;
        drive_frame(V, H, 0, fd, fe, after);
        n_vec++; if (mon_n - base != 32) begin n_err++; $display("FAIL luma_count got=%0d exp=32", mon_n - base); end
        for (int i = 0; i < 32; i++) begin
            n_vec++;
            if (mon_addr[base+i] !== 5'(i) || mon_buf[base+i] !== 2'd0 || mon_data[base+i] !== 16'(i)) begin
                n_err++;
                $display("FAIL luma_wr[%0d] got addr=%0d buf=%0d data=%h exp addr=%0d buf=0 data=%h",
                         i, mon_addr[base+i], mon_buf[base+i], mon_data[base+i], i, 16'(i));
            end
        end
        n_vec++; if (fd !== 1'b1 || fe !== 1'b0) begin n_err++; $display("FAIL luma_done got done=%b err=%b exp 1/0", fd, fe); end
        n_vec++; if (after !== 1'b0) begin n_err++; $display("FAIL luma_pulse_width got=%b exp=0", after); end
        n_vec++; if (DoneBuf !== 2'd0) begin n_err++; $display("FAIL luma_donebuf got=%0d exp=0", DoneBuf); end
    endtask

    task automatic test_binary();
        int base; logic fd, fe, after;
        Mode = 2'd1; Threshold = 8'h80; base = mon_n;
        drive_frame(V, H, 1, fd, fe, after);
        n_vec++; if (mon_n - base != 32) begin n_err++; $display("FAIL bin_count got=%0d exp=32", mon_n - base); end
        for (int i = 0; i < 32; i++) begin
            n_vec++;
            if (mon_data[base+i] !== 16'(i % 2) || mon_buf[base+i] !== 2'd1) begin
                n_err++;
                $display("FAIL bin_wr[%0d] got data=%h buf=%0d exp data=%h buf=1", i, mon_data[base+i], mon_buf[base+i], 16'(i % 2));
            end
        end
        n_vec++; if (fd !== 1'b1 || DoneBuf !== 2'd1) begin n_err++; $display("FAIL bin_done got done=%b buf=%0d exp 1/1", fd, DoneBuf); end
        base = mon_n;
        drive_frame(V, H, 0, fd, fe, after);
        n_vec++; if (mon_n - base != 32 || mon_buf[base] !== 2'd0) begin n_err++; $display("FAIL bin_third got count=%0d buf=%0d exp 32/0", mon_n - base, mon_buf[base]); end
        n_vec++; if (fd !== 1'b1 || DoneBuf !== 2'd0) begin n_err++; $display("FAIL bin_third_done got done=%b buf=%0d exp 1/0", fd, DoneBuf); end
    endtask

    task automatic test_rgb_decimate();
        int base; int k; logic fd, fe, after;
        Mode = 2'd2; Decimate = 1'b0; base = mon_n;
        drive_frame(V, H, 2, fd, fe, after);
        n_vec++; if (mon_n - base != 32) begin n_err++; $display("FAIL rgb_count got=%0d exp=32", mon_n - base); end
        for (int i = 0; i < 32; i++) begin
            n_vec++;
            if (mon_data[base+i] !== 16'hF81F || mon_buf[base+i] !== 2'd1) begin
                n_err++;
                $display("FAIL rgb_wr[%0d] got data=%h buf=%0d exp data=f81f buf=1", i, mon_data[base+i], mon_buf[base+i]);
            end
        end
        Decimate = 1'b1; base = mon_n;
        drive_frame(V, H, 3, fd, fe, after);
        n_vec++; if (mon_n - base != 8) begin n_err++; $display("FAIL dec_count got=%0d exp=8", mon_n - base); end
        for (int i = 0; i < 8; i++) begin
            k = (i / 4) * 2 * H + (i % 4) * 2;
            n_vec++;
            if (mon_addr[base+i] !== 5'(i) || mon_data[base+i] !== {8'hF8, 8'(k)} || mon_buf[base+i] !== 2'd0) begin
                n_err++;
                $display("FAIL dec_wr[%0d] got addr=%0d data=%h buf=%0d exp addr=%0d data=%h buf=0",
                         i, mon_addr[base+i], mon_data[base+i], mon_buf[base+i], i, {8'hF8, 8'(k)});
            end
        end
        n_vec++; if (fd !== 1'b1 || DoneBuf !== 2'd0) begin n_err++; $display("FAIL dec_done got done=%b buf=%0d exp 1/0", fd, DoneBuf); end
        Decimate = 1'b0; Mode = 2'd0;
    endtask

    task automatic test_lock();
        int base; int base3; int d0; int e0; logic fd, fe, after;
        Reset = 1'b1;
        repeat (2) @(negedge PCLK);
        Reset = 1'b0;
        drive_frame(V, H, 0, fd, fe, after);
        n_vec++; if (DoneBuf !== 2'd0 || DoneBuf3 !== 2'd0) begin n_err++; $display("FAIL lock_pre got buf2=%0d buf3=%0d exp 0/0", DoneBuf, DoneBuf3); end
        LockValid = 1'b1; LockBuf = 2'd1;
        base = mon_n; base3 = wr3_n; d0 = done_n; e0 = ferr_n;
        drive_frame(V, H, 0, fd, fe, after);
        n_vec++; if (mon_n != base) begin n_err++; $display("FAIL lock_drop_writes got=%0d exp=0", mon_n - base); end
        n_vec++; if (done_n != d0 || ferr_n != e0) begin n_err++; $display("FAIL lock_drop_pulses got done=%0d err=%0d exp 0/0", done_n - d0, ferr_n - e0); end
        n_vec++; if (DropCount !== 8'd1) begin n_err++; $display("FAIL lock_dropcount got=%0d exp=1", DropCount); end
        n_vec++; if (DoneBuf !== 2'd0) begin n_err++; $display("FAIL lock_donebuf got=%0d exp=0", DoneBuf); end
        n_vec++; if (wr3_n - base3 != 32 || wr3_buf !== 2'd2) begin n_err++; $display("FAIL lock3_writes got count=%0d buf=%0d exp 32/2", wr3_n - base3, wr3_buf); end
        n_vec++; if (DoneBuf3 !== 2'd2 || DropCount3 !== 8'd0) begin n_err++; $display("FAIL lock3_done got buf=%0d drop=%0d exp 2/0", DoneBuf3, DropCount3); end
        LockValid = 1'b0; LockBuf = 2'd0;
    endtask

    task automatic test_frame_err();
        int base; logic fd, fe, after;
        drive_frame(V, 6, 0, fd, fe, after);
        n_vec++; if (fd !== 1'b0 || fe !== 1'b1 || after !== 1'b0) begin n_err++; $display("FAIL short_line got done=%b err=%b after=%b exp 0/1/0", fd, fe, after); end
        n_vec++; if (DoneBuf !== 2'd0) begin n_err++; $display("FAIL short_line_donebuf got=%0d exp=0", DoneBuf); end
        drive_frame(3, H, 0, fd, fe, after);
        n_vec++; if (fd !== 1'b0 || fe !== 1'b1) begin n_err++; $display("FAIL short_frame got done=%b err=%b exp 0/1", fd, fe); end
        n_vec++; if (DoneBuf !== 2'd0) begin n_err++; $display("FAIL short_frame_donebuf got=%0d exp=0", DoneBuf); end
        base = mon_n;
        drive_frame(V, H, 0, fd, fe, after);
        n_vec++; if (mon_n - base != 32 || mon_buf[base] !== 2'd1) begin n_err++; $display("FAIL err_recover got count=%0d buf=%0d exp 32/1", mon_n - base, mon_buf[base]); end
        n_vec++; if (fd !== 1'b1 || DoneBuf !== 2'd1) begin n_err++; $display("FAIL err_recover_done got done=%b buf=%0d exp 1/1", fd, DoneBuf); end
    endtask

    task automatic test_reset_mid_frame();
        int base; int d0; int e0; logic fd, fe, after;
        drive_frame(V, H, 0, fd, fe, after);
        n_vec++; if (DoneBuf !== 2'd0) begin n_err++; $display("FAIL mid_pre got=%0d exp=0", DoneBuf); end
        @(negedge PCLK);
        VSYNC = 1'b0;
        repeat (3) @(negedge PCLK);
        for (int b = 0; b < 5; b++) begin
            HREF = 1'b1; D = 8'h40 + 8'(b);
            @(negedge PCLK);
        end
        D = 8'h55; Reset = 1'b1;
        d0 = done_n; e0 = ferr_n;
        @(negedge PCLK);
        n_vec++; if (WrEn !== 1'b0) begin n_err++; $display("FAIL mid_reset_wren got=%b exp=0", WrEn); end
        n_vec++; if (DoneBuf !== 2'd1 || DropCount !== 8'd0 || WrAddr !== 5'd0) begin n_err++; $display("FAIL mid_reset_outs got buf=%0d drop=%0d addr=%0d exp 1/0/0", DoneBuf, DropCount, WrAddr); end
        Reset = 1'b0; HREF = 1'b0; VSYNC = 1'b1;
        repeat (4) @(negedge PCLK);
        n_vec++; if (done_n != d0 || ferr_n != e0) begin n_err++; $display("FAIL mid_reset_pulses got done=%0d err=%0d exp 0/0", done_n - d0, ferr_n - e0); end
        base = mon_n;
        drive_frame(V, H, 0, fd, fe, after);
        n_vec++; if (mon_n - base != 32 || mon_buf[base] !== 2'd0 || mon_addr[base+31] !== 5'd31) begin n_err++; $display("FAIL mid_next_frame got count=%0d buf=%0d exp 32/0", mon_n - base, mon_buf[base]); end
        n_vec++; if (fd !== 1'b1 || DoneBuf !== 2'd0) begin n_err++; $display("FAIL mid_next_done got done=%b buf=%0d exp 1/0", fd, DoneBuf); end
    endtask

    initial begin
        test_reset();
        test_luma();
        test_binary();
        test_rgb_decimate();
        test_lock();
        test_frame_err();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
